jk_stim_driver: RTL and testbench

- Synthesizable driver/checker for the JK flip-flop interface: the initiating end that generates the `j`/`k` inputs and checks the `q`/`qb` response.
- Drives a fixed excitation sequence (hold, set, reset, toggle) into an external JKFF and keeps its own reference model of the flip-flop.
- Compares the returned `q`/`qb` against that model every cycle and reports an error count and pass/fail.
- Used for on-chip self-test of JK flip-flop instances and as a reusable bench component.

---
 rtl/jk_stim_driver.sv | 258 +++++++++++++++++++++++++
 tb/tb_jk_stim_driver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/jk_stim_driver.sv
// ============================================================================
// jk_stim_driver
// ----------------------------------------------------------------------------
// Purpose:
//   Initiating end of a JK flip-flop self-test. Drives a fixed excitation
//   sequence (hold, set, hold, toggle, toggle, reset, toggle, reset) into an
//   external JKFF through registered j/k outputs. It keeps its own reference
//   model of the flip-flop and compares the returned q/qb against that model
//   on every checked cycle. The result is a saturating error count and a
//   pass/fail flag.
//
// Run sequence:
//   IDLE -> INIT (1 cycle, j=0 k=1 forces q=0) -> RUN (8*NUM_PASSES cycles)
//        -> DRAIN (1 cycle, last compare) -> DONE (level, waits for start)
//   start is sampled only in IDLE and DONE. While busy, start is ignored.
//
// Handshake:
//   start is a level/pulse request. It is accepted on any rising edge where
//   the block is in IDLE or DONE. busy rises on that same edge.
//   done/pass stay valid (level) until the next accepted start or rst.
//
// Parameters:
//   NUM_PASSES : number of repetitions of the 8-step sequence (1..255)
//   ERR_W      : width of the saturating mismatch counter
//
// Ports:
//   clk             in   rising-edge clock, shared with the JKFF under test
//   rst             in   synchronous active-high reset
//   start           in   begin a test run (IDLE/DONE only)
//   j, k            out  registered drives to the JKFF
//   q_in, qb_in     in   JKFF response
//   busy            out  high in INIT, RUN, DRAIN
//   done            out  high in DONE
//   pass            out  done && err_count == 0
//   err_count       out  saturating mismatch count of the current/last run
//   state_dbg       out  current FSM state encoding (debug observation)
//
// Optional feature (macro JK_STIM_FIRST_ERR_EN):
//   first_err_valid out  a mismatch has been recorded in this run
//   first_err_loc   out  {pass_cnt[7:0], step[2:0]} of the first mismatch;
//                        a DRAIN-cycle mismatch reads {NUM_PASSES[7:0], 3'd0}
// ============================================================================
module jk_stim_driver #(
    parameter int NUM_PASSES = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             j,
    output logic             k,
    input  logic             q_in,
    input  logic             qb_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
`ifdef JK_STIM_FIRST_ERR_EN
    output logic             first_err_valid,
    output logic [10:0]      first_err_loc,
`endif
    output logic [2:0]       state_dbg
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Excitation tables, bit i is the drive for step i.
    //   step : 0 1 2 3 4 5 6 7
    //   j    : 0 1 0 1 1 0 1 0
    //   k    : 0 0 0 1 1 1 1 1
    // ------------------------------------------------------------------
    localparam logic [7:0] J_SEQ = 8'b0101_1010;
    localparam logic [7:0] K_SEQ = 8'b1111_1000;

    localparam logic [7:0]       LAST_PASS = 8'(NUM_PASSES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE   = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_ZERO  = {ERR_W{1'b0}};

    // ------------------------------------------------------------------
    // Internal state
    // ------------------------------------------------------------------
    state_t     state;
    logic       exp_q;     // reference model of the JKFF output
    logic       chk_en;    // compare enable: RUN and DRAIN cycles
    logic [2:0] step;      // position in the 8-step sequence
    logic [7:0] pass_cnt;  // completed passes in this run

    logic             mismatch;
    logic [ERR_W-1:0] err_next;
    logic [2:0]       step_nxt;

`ifdef JK_STIM_FIRST_ERR_EN
    localparam logic [7:0] NP8 = 8'(NUM_PASSES);
    logic [10:0] loc_now;
`endif

    // ------------------------------------------------------------------
    // Reference JK model: 00 hold, 01 reset, 10 set, 11 toggle.
    // ------------------------------------------------------------------
    function automatic logic jk_next(input logic jj, input logic kk,
                                     input logic qq);
        logic r;
        case ({jj, kk})
            2'b00:   r = qq;
            2'b01:   r = 1'b0;
            2'b10:   r = 1'b1;
            default: r = ~qq;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Checker. Both rails are compared, so a JKFF whose qb does not
    // track ~q is caught even when q itself is correct.
    // ------------------------------------------------------------------
    always_comb begin
        mismatch = chk_en && ((q_in != exp_q) || (qb_in != ~exp_q));
        err_next = err_count;
        if (mismatch && (err_count != ERR_MAX)) begin
            err_next = err_count + ERR_ONE;
        end
        step_nxt = step + 3'd1;
    end

`ifdef JK_STIM_FIRST_ERR_EN
    // During DRAIN pass_cnt has already wrapped past the last pass; the
    // location is pinned explicitly so it does not depend on that detail.
    always_comb begin
        loc_now = {pass_cnt, step};
        if (state == S_DRAIN) begin
            loc_now = {NP8, 3'd0};
        end
    end
`endif

    // ------------------------------------------------------------------
    // Main FSM. All outputs are registered here.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            j         <= 1'b0;
            k         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= ERR_ZERO;
            exp_q     <= 1'b0;
            chk_en    <= 1'b0;
            step      <= 3'd0;
            pass_cnt  <= 8'd0;
`ifdef JK_STIM_FIRST_ERR_EN
            first_err_valid <= 1'b0;
            first_err_loc   <= 11'd0;
`endif
        end else begin
            // Default: accumulate mismatches. The start branch below
            // overrides this with a clear; chk_en is low there anyway.
            err_count <= err_next;

`ifdef JK_STIM_FIRST_ERR_EN
            if (mismatch && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_loc   <= loc_now;
            end
`endif

            case (state)
                S_IDLE, S_DONE: begin
                    j <= 1'b0;
                    k <= 1'b0;
                    if (start) begin
                        state     <= S_INIT;
                        j         <= 1'b0;
                        k         <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= ERR_ZERO;
`ifdef JK_STIM_FIRST_ERR_EN
                        first_err_valid <= 1'b0;
                        first_err_loc   <= 11'd0;
`endif
                    end
                end

                S_INIT: begin
                    // The JKFF takes (0,1) on this edge, so q=0 from here.
                    state    <= S_RUN;
                    exp_q    <= 1'b0;
                    chk_en   <= 1'b1;
                    step     <= 3'd0;
                    pass_cnt <= 8'd0;
                    j        <= J_SEQ[0];
                    k        <= K_SEQ[0];
                end

                S_RUN: begin
                    // Model advances with the drive the JKFF sees on this
                    // same edge, keeping exp_q aligned with the returned q.
                    exp_q <= jk_next(j, k, exp_q);
                    if (step == 3'd7) begin
                        step     <= 3'd0;
                        pass_cnt <= pass_cnt + 8'd1;
                        if (pass_cnt == LAST_PASS) begin
                            state <= S_DRAIN;
                            j     <= 1'b0;
                            k     <= 1'b0;
                        end else begin
                            j <= J_SEQ[0];
                            k <= K_SEQ[0];
                        end
                    end else begin
                        step <= step_nxt;
                        j    <= J_SEQ[step_nxt];
                        k    <= K_SEQ[step_nxt];
                    end
                end

                S_DRAIN: begin
                    // Last compare happens in this cycle; the result is
                    // folded into pass using the post-compare count.
                    state  <= S_DONE;
                    chk_en <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    pass   <= (err_next == ERR_ZERO);
                    j      <= 1'b0;
                    k      <= 1'b0;
                end

                default: begin
                    state  <= S_IDLE;
                    chk_en <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    pass   <= 1'b0;
                    j      <= 1'b0;
                    k      <= 1'b0;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_jk_stim_driver.sv
// ============================================================================
// tb_jk_stim_driver
// ----------------------------------------------------------------------------
// Directed bench for jk_stim_driver. A behavioural JKFF with selectable
// faults answers the main instance. A second instance with ERR_W=3 sees the
// same start/q/qb so saturation can be observed on an identical run.
//   fault_mode 0 : correct JKFF
//   fault_mode 1 : q stuck at 0, qb = ~q
//   fault_mode 2 : qb wired equal to q
// ============================================================================
module tb_jk_stim_driver;

    localparam int NUM_PASSES = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT wiring ----------------
    logic       j, k, busy, done, pass;
    logic [7:0] err_count;
    logic [2:0] state_dbg;
    logic       q_in, qb_in;

    logic       j_s, k_s, busy_s, done_s, pass_s;
    logic [2:0] err_count_s;
    logic [2:0] state_dbg_s;

`ifdef JK_STIM_FIRST_ERR_EN
    logic        first_err_valid, first_err_valid_s;
    logic [10:0] first_err_loc, first_err_loc_s;
`endif

    jk_stim_driver #(.NUM_PASSES(NUM_PASSES), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .j(j), .k(k),
        .q_in(q_in), .qb_in(qb_in), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count),
`ifdef JK_STIM_FIRST_ERR_EN
        .first_err_valid(first_err_valid), .first_err_loc(first_err_loc),
`endif
        .state_dbg(state_dbg)
    );

    jk_stim_driver #(.NUM_PASSES(NUM_PASSES), .ERR_W(3)) dut_small (
        .clk(clk), .rst(rst), .start(start), .j(j_s), .k(k_s),
        .q_in(q_in), .qb_in(qb_in), .busy(busy_s), .done(done_s),
        .pass(pass_s), .err_count(err_count_s),
`ifdef JK_STIM_FIRST_ERR_EN
        .first_err_valid(first_err_valid_s), .first_err_loc(first_err_loc_s),
`endif
        .state_dbg(state_dbg_s)
    );

    // ---------------- behavioural JKFF with faults ----------------
    int   fault_mode = 0;
    logic jk_q = 1'b0;
    always @(posedge clk) begin
        case ({j, k})
            2'b00:   jk_q <= jk_q;
            2'b01:   jk_q <= 1'b0;
            2'b10:   jk_q <= 1'b1;
            default: jk_q <= ~jk_q;
        endcase
    end
    assign q_in  = (fault_mode == 1) ? 1'b0 : jk_q;
    assign qb_in = (fault_mode == 2) ? q_in : ~q_in;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {j,k} per RUN step, hand-derived from the excitation table.
    logic [1:0] exp_jk [8] = '{2'b00, 2'b10, 2'b00, 2'b11,
                               2'b11, 2'b01, 2'b11, 2'b01};

    // ---------------- driver tasks ----------------
    // Advance one rising edge, then settle 1 time unit before touching
    // inputs or sampling outputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits for done after a start edge; cycles counts edges from the
    // start edge (the start edge itself is cycle 0).
    task automatic wait_done(input int already, output int cycles);
        cycles = already;
        while (!done && cycles < 100) begin
            tick();
            cycles++;
        end
        if (!done) check("done_timeout", 32'(cycles), 32'd18);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_jk", 32'({j, k}), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);

        // --- Clean run: sequence, latency, pass ---
        fault_mode = 0;
        pulse_start();
        check("init_busy", 32'(busy), 32'd1);
        check("init_jk", 32'({j, k}), 32'b01);
        cyc = 0;
        for (int i = 0; i < 8 * NUM_PASSES; i++) begin
            tick();
            cyc++;
            check($sformatf("run_jk_%0d", i), 32'({j, k}), 32'(exp_jk[i % 8]));
        end
        tick();
        cyc++;
        check("drain_jk", 32'({j, k}), 32'd0);
        check("drain_busy", 32'(busy), 32'd1);
        wait_done(cyc, cyc);
        check("clean_latency", 32'(cyc), 32'd18);
        check("clean_err", 32'(err_count), 32'd0);
        check("clean_pass", 32'(pass), 32'd1);
        check("clean_busy", 32'(busy), 32'd0);
        check("clean_err_small", 32'(err_count_s), 32'd0);

        // --- q stuck at 0 ---
        fault_mode = 1;
        pulse_start();
        wait_done(0, cyc);
        check("stuck_latency", 32'(cyc), 32'd18);
        check("stuck_err", 32'(err_count), 32'd8);
        check("stuck_pass", 32'(pass), 32'd0);
        check("stuck_done", 32'(done), 32'd1);
`ifdef JK_STIM_FIRST_ERR_EN
        check("stuck_fe_valid", 32'(first_err_valid), 32'd1);
        check("stuck_fe_loc", 32'(first_err_loc), 32'({8'd0, 3'd2}));
`endif

        // --- start in DONE: err cleared, second run passes ---
        fault_mode = 0;
        pulse_start();
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_err", 32'(err_count), 32'd0);
        check("restart_done", 32'(done), 32'd0);
        wait_done(0, cyc);
        check("restart_pass", 32'(pass), 32'd1);

        // --- qb equal to q: every compare fails, small counter saturates ---
        fault_mode = 2;
        pulse_start();
        wait_done(0, cyc);
        check("qbq_err", 32'(err_count), 32'd17);
        check("qbq_pass", 32'(pass), 32'd0);
        check("qbq_err_small", 32'(err_count_s), 32'd7);
        check("qbq_done_small", 32'(done_s), 32'd1);

        // --- reset at RUN step4 of pass0 ---
        pulse_start();
        for (int i = 0; i < 5; i++) tick();
        check("mid_jk_step4", 32'({j, k}), 32'b11);
        check("mid_err_nonzero", 32'(err_count != 0), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_jk", 32'({j, k}), 32'd0);
        check("midrst_err", 32'(err_count), 32'd0);
        check("midrst_state", 32'(state_dbg), 32'd0);
        fault_mode = 0;
        pulse_start();
        wait_done(0, cyc);
        check("postrst_latency", 32'(cyc), 32'd18);
        check("postrst_pass", 32'(pass), 32'd1);

        // --- start while busy (RUN step3) is ignored ---
        pulse_start();
        for (int i = 0; i < 4; i++) tick();
        check("ign_jk_step3", 32'({j, k}), 32'b11);
        pulse_start();
        check("ign_busy", 32'(busy), 32'd1);
        check("ign_jk_step4", 32'({j, k}), 32'b11);
        wait_done(5, cyc);
        check("ign_latency", 32'(cyc), 32'd18);
        check("ign_pass", 32'(pass), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
